// File: rtl/reg_select_encoder_if.sv
// Request/selection bundle for reg_select_encoder: a vector-in handshake and a
// selection-out handshake. The DUT uses the slave modport; the producer/consumer side uses master.
interface reg_select_encoder_if;
    // Both handshakes follow strict valid/ready semantics. A transfer happens on a
    // rising clk edge where valid and ready are both high. A valid payload holds
    // stable until it transfers. Ready may change freely and carries no commitment.
    logic        req_valid;
    logic [15:0] req_vec;
    logic        req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  select_reg;
    logic        size;
    logic        select_high_low;
    logic        conflict;
    logic        dbg_state;

    modport slave (
        input  req_valid, req_vec, out_ready,
        output req_ready, out_valid, select_reg, size, select_high_low, conflict, dbg_state
    );

    modport master (
        output req_valid, req_vec, out_ready,
        input  req_ready, out_valid, select_reg, size, select_high_low, conflict, dbg_state
    );
endinterface

// File: rtl/reg_select_encoder.sv
// Turns a multi-hot 16-bit register-enable vector into one (reg, size, high/low)
// selection per handshake, lowest set bit first, and flags 16/8-bit overlaps.
module reg_select_encoder (
    input  logic                  clk,
    input  logic                  reset_n,
    reg_select_encoder_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t      r_state;
    logic [15:0] r_pending;
    logic        r_conflict;
    logic        r_req_ready;
    logic        r_out_valid;
    logic [2:0]  r_select_reg;
    logic        r_size;
    logic        r_select_high_low;

    logic [15:0] w_next_pending;
    logic        w_req_conflict;
    logic [4:0]  w_enc_req;
    logic [4:0]  w_enc_next;

    // Packs {select_reg, size, select_high_low} for the lowest set bit of v.
    function automatic logic [4:0] encode(input logic [15:0] v);
        logic [3:0] k;
        logic [4:0] res;
        k = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) k = 4'(i);
        end
        if (v == 16'd0)        res = 5'd0;
        else if (k < 4'd8)     res = {k[2:0], 1'b1, 1'b0};
        else if (k < 4'd12)    res = {1'b0, k[1:0], 1'b0, 1'b1};
        else                   res = {1'b0, k[1:0], 1'b0, 1'b0};
        return res;
    endfunction

    // Subtracting one and masking drops exactly the lowest set bit.
    assign w_next_pending = r_pending & (r_pending - 16'd1);
    assign w_req_conflict = |(bus.req_vec[3:0] & (bus.req_vec[11:8] | bus.req_vec[15:12]));
    assign w_enc_req      = encode(bus.req_vec);
    assign w_enc_next     = encode(w_next_pending);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= IDLE;
            r_pending         <= 16'd0;
            r_conflict        <= 1'b0;
            r_req_ready       <= 1'b1;
            r_out_valid       <= 1'b0;
            r_select_reg      <= 3'd0;
            r_size            <= 1'b0;
            r_select_high_low <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_pending  <= bus.req_vec;
                        r_conflict <= w_req_conflict;
                        if (bus.req_vec != 16'd0) begin
                            r_state     <= ISSUE;
                            r_req_ready <= 1'b0;
                            r_out_valid <= 1'b1;
                            {r_select_reg, r_size, r_select_high_low} <= w_enc_req;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.out_ready) begin
                        r_pending <= w_next_pending;
                        if (w_next_pending == 16'd0) begin
                            r_state     <= IDLE;
                            r_req_ready <= 1'b1;
                            r_out_valid <= 1'b0;
                            {r_select_reg, r_size, r_select_high_low} <= 5'd0;
                        end else begin
                            {r_select_reg, r_size, r_select_high_low} <= w_enc_next;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = r_req_ready;
    assign bus.out_valid       = r_out_valid;
    assign bus.select_reg      = r_select_reg;
    assign bus.size            = r_size;
    assign bus.select_high_low = r_select_high_low;
    assign bus.conflict        = r_conflict;
    assign bus.dbg_state       = r_state;
endmodule

// File: tb/tb_reg_select_encoder.sv
// Bench for reg_select_encoder: scenario tasks drive vectors and compare every
// emitted selection against a bit-order list built from the register layout.
module tb_reg_select_encoder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    reg_select_encoder_if bus();

    reg_select_encoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    logic       exp_conflict;

    // Expected selections: walk register enables in bit order using the layout table.
    function automatic void model_load(input logic [15:0] v);
        exp_q.delete();
        exp_conflict = 1'b0;
        for (int b = 0; b < 16; b++) begin
            if (v[b]) begin
                if (b < 8)       exp_q.push_back({3'(b), 1'b1, 1'b0});
                else if (b < 12) exp_q.push_back({3'(b - 8), 1'b0, 1'b1});
                else             exp_q.push_back({3'(b - 12), 1'b0, 1'b0});
            end
        end
        for (int r = 0; r < 4; r++) begin
            if (v[r] && (v[r + 8] || v[r + 12])) exp_conflict = 1'b1;
        end
    endfunction

    function automatic logic [4:0] obs_sel();
        return {bus.select_reg, bus.size, bus.select_high_low};
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL %s_idle_timeout: req_ready got %b exp 1", name, bus.req_ready);
        end
    endtask

    // Accepts v, then consumes the burst with optional initial stall and random back-pressure.
    task automatic run_vec(input string name, input logic [15:0] v, input int stall_n,
                           input int ready_pct, input bit toggle_req);
        int cyc = 0;
        wait_idle(name);
        model_load(v);
        bus.req_valid = 1'b1;
        bus.req_vec   = v;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (exp_q.size() > 0 && cyc < 300) begin
            checks++;
            if (bus.out_valid !== 1'b1 || obs_sel() !== exp_q[0]) begin
                errors++;
                $display("FAIL %s_sel[%0d]: got valid=%b sel=%h exp valid=1 sel=%h",
                         name, cyc, bus.out_valid, obs_sel(), exp_q[0]);
            end
            checks++;
            if (bus.conflict !== exp_conflict) begin
                errors++;
                $display("FAIL %s_conflict[%0d]: got %b exp %b", name, cyc, bus.conflict, exp_conflict);
            end
            if (toggle_req) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_vec   = 16'($urandom);
            end
            bus.out_ready = (cyc >= stall_n) && ($urandom_range(1, 100) <= ready_pct);
            if (bus.out_ready) void'(exp_q.pop_front());
            cyc++;
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL %s_burst_timeout: remaining got %0d exp 0", name, exp_q.size());
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1 || obs_sel() !== 5'd0) begin
            errors++;
            $display("FAIL %s_bubble: got valid=%b ready=%b sel=%h exp valid=0 ready=1 sel=00",
                     name, bus.out_valid, bus.req_ready, obs_sel());
        end
        checks++;
        if (bus.conflict !== exp_conflict) begin
            errors++;
            $display("FAIL %s_conflict_hold: got %b exp %b", name, bus.conflict, exp_conflict);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_vec   = 16'd0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0 || obs_sel() !== 5'd0 || bus.conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b sel=%h conf=%b exp 1 0 00 0",
                     bus.req_ready, bus.out_valid, obs_sel(), bus.conflict);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b valid=%b exp 1 0", bus.req_ready, bus.out_valid);
        end
    endtask

    task automatic test_single();
        run_vec("single_ax", 16'h0001, 0, 100, 1'b0);
    endtask

    task automatic test_conflict();
        run_vec("conflict_8101", 16'h8101, 0, 100, 1'b0);
    endtask

    task automatic test_zero();
        run_vec("zero_vec", 16'h0000, 0, 100, 1'b0);
    endtask

    task automatic test_backpressure();
        run_vec("stall_0480", 16'h0480, 5, 100, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        wait_idle("mid_reset");
        model_load(16'hFFFF);
        bus.req_valid = 1'b1;
        bus.req_vec   = 16'hFFFF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || obs_sel() !== exp_q[0]) begin
                errors++;
                $display("FAIL mid_reset_sel[%0d]: got valid=%b sel=%h exp valid=1 sel=%h",
                         i, bus.out_valid, obs_sel(), exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1 || obs_sel() !== 5'd0 || bus.conflict !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: got valid=%b ready=%b sel=%h conf=%b exp 0 1 00 0",
                     bus.out_valid, bus.req_ready, obs_sel(), bus.conflict);
        end
        exp_q.delete();
        bus.out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_vec("after_reset_0020", 16'h0020, 0, 100, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_vec("full_ffff", 16'hFFFF, 0, 100, 1'b1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (t % 3 == 1) v = v & 16'($urandom);
            run_vec($sformatf("rand%0d", t), v, $urandom_range(0, 3), $urandom_range(40, 100),
                    1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_zero();
        test_backpressure();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_select_encoder.md
Name: reg_select_encoder

Overview:
- Inverse of the register-select decoder. It accepts a 16-bit one-hot/multi-hot register-enable vector and produces one register selection at a time.
- Each selection is a (select_reg, size, select_high_low) triple, emitted one per handshake in fixed priority order.
- Sits between the execution/write-back logic, which flags every register an instruction touches, and the register-file access port, which takes one encoded selection per cycle.
- Also flags overlapping 16-bit/8-bit requests to the same register.

Parameters:
- None. The mapping is fixed by the 16-bit register-enable layout.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request vector present
- req_vec  input  16  register enables: bit0..7 = AX,BX,CX,DX,SI,DI,SP,BP; bit8..11 = AH,BH,CH,DH; bit12..15 = AL,BL,CL,DL
- req_ready  output  1  block can accept a new vector
- out_valid  output  1  encoded selection present
- out_ready  input  1  consumer accepts selection
- select_reg  output  3  register index
- size  output  1  1 = 16-bit, 0 = 8-bit
- select_high_low  output  1  1 = high byte, 0 = low byte; always 0 when size = 1
- conflict  output  1  last accepted vector had a 16-bit register together with one of its own byte halves

Behaviour:
- One clock. reset_n is asynchronous and active-low.
- State and storage: two states, IDLE and ISSUE. A 16-bit pending register holds the bits not yet issued.
- Reset (asynchronous, any time, including mid-burst):
  - state = IDLE, pending = 0, conflict = 0.
  - Outputs: req_ready = 1, out_valid = 0, select_reg = 0, size = 0, select_high_low = 0.
- req_ready = (state == IDLE).
- out_valid = (state == ISSUE).
- Accept: on a rising edge with state IDLE and req_valid = 1:
  - pending <= req_vec.
  - conflict <= OR over i=0..3 of (req_vec[i] & (req_vec[i+8] | req_vec[i+12])).
  - If req_vec != 0, go to ISSUE; otherwise stay IDLE (vector consumed, no output, conflict = 0).
- conflict holds its value until the next accept.
- Latency: vector accepted at edge N -> first out_valid in cycle N+1.
- Encoding (combinational from pending, lowest set bit k wins):
  - k in 0..7: select_reg = k, size = 1, select_high_low = 0.
  - k in 8..11: select_reg = k-8, size = 0, select_high_low = 1.
  - k in 12..15: select_reg = k-12, size = 0, select_high_low = 0.
  - When out_valid = 0, all three fields are 0.
- Handshake:
  - On a rising edge with out_valid & out_ready, clear bit k in pending.
  - If the cleared pending is 0, go to IDLE; otherwise stay in ISSUE.
  - With out_ready low, pending and all output fields hold stable. The consumer may hold off indefinitely.
- Throughput and burst length:
  - One selection per cycle while out_ready = 1.
  - A vector with n set bits takes n handshake cycles.
  - One bubble cycle (req_ready high) follows before the next output.
- req_valid while in ISSUE is ignored; no back-pressure beyond req_ready.
- Conflict does not suppress issue: every set bit is emitted, including overlapping ones.
- Bits 4..7 have no byte forms, so they never raise conflict.
- Design target: 120-400 lines of RTL.

Test Plan:
- Reset, then req_vec = 16'h0001 with req_valid for 1 cycle -> next cycle out_valid = 1, select_reg = 0, size = 1, hl = 0. With out_ready = 1, out_valid drops after 1 cycle and req_ready returns to 1.
- req_vec = 16'h8101 (AX, AH, DL), out_ready = 1 -> three consecutive outputs: (0,1,0), (0,0,1), (3,0,0). conflict = 1 from the cycle after accept until the next accept.
- req_vec = 16'h0480 (BP, CH), out_ready held low 5 cycles then high -> (7,1,0) stable for 6 cycles, then (2,0,1), then IDLE. conflict = 0.
- req_vec = 16'h0000 with req_valid -> no out_valid; req_ready stays 1; conflict clears to 0 if previously set.
- Assert reset_n low mid-burst of 16'hFFFF after 4 issues -> out_valid = 0 and req_ready = 1 immediately (asynchronously). After release, a new req_vec = 16'h0020 yields only (5,1,0).
- req_vec = 16'hFFFF with out_ready = 1 -> 16 outputs in bit order 0..15. Toggling req_valid during the burst has no effect.
